// File: rtl/md_issue_ctrl_if.sv
// Issue-side bundle between the E stage, the issue controller and the multiply/divide unit.
// The master drives requests and returns the unit's busy; the slave drives start/operands/stall.
interface md_issue_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use;
  logic        flush;
  logic        md_busy;
  logic [2:0]  start;
  logic [31:0] p1;
  logic [31:0] p2;
  logic        stall;
  logic        done;
  logic        err;

  modport master (
    output op_valid, op_code, a, b, md_use, flush, md_busy,
    input  start, p1, p2, stall, done, err
  );

  modport slave (
    input  op_valid, op_code, a, b, md_use, flush, md_busy,
    output start, p1, p2, stall, done, err
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Mult/div issue controller: registers operands, pulses start one cycle after accept, times the busy window.
// Requests and HI/LO users are stalled (not dropped) while an operation is outstanding; err is sticky.
module md_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  md_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] p1_q, p1_d;
  logic [31:0] p2_q, p2_d;
  logic        armed_q, armed_d;
  logic        err_q, err_d;
  logic [2:0]  start_c;
  logic        done_c;
  logic        op_ok;
  logic        exp_busy;

  assign op_ok = bus.op_valid && (bus.op_code != 3'd0) && (bus.op_code <= 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      p1_q    <= 32'd0;
      p2_q    <= 32'd0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    armed_d = armed_q;
    start_c = 3'd0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_ok && !bus.flush) begin
          op_d    = bus.op_code;
          p1_d    = bus.a;
          p2_d    = bus.b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A flush here withdraws the request before the unit ever sees it.
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          start_c = op_q;
          cnt_d   = (op_q <= 3'd2) ? 4'(MULT_LAT) : 4'(DIV_LAT);
          armed_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The unit's busy is meaningless until it has been started at least once.
  assign exp_busy = (state_q == WAIT);
  assign err_d    = err_q | (armed_q && (bus.md_busy != exp_busy));

  assign bus.start = start_c;
  assign bus.p1    = p1_q;
  assign bus.p2    = p2_q;
  assign bus.stall = (state_q != IDLE) && (bus.md_use || bus.op_valid);
  assign bus.done  = done_c;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a behavioural multiply/divide busy model.
module tb_md_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_issue_ctrl_if bus();

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   total = 0;
  int   bad   = 0;
  int   bcnt  = 0;
  int   nstart = 0;
  logic force_lo = 1'b0;

  // Unit model: busy for L cycles after the edge that samples a nonzero start.
  always @(posedge clk) begin
    if (bus.start != 3'd0) bcnt <= (bus.start <= 3'd2) ? 5 : 10;
    else if (bcnt > 0)     bcnt <= bcnt - 1;
  end
  assign bus.md_busy = (bcnt != 0) && !force_lo;

  always @(negedge clk) if (bus.start != 3'd0) nstart <= nstart + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_phase(input int lat, input logic stall_exp);
    for (int i = 1; i <= lat; i++) begin
      tick();
      smp();
      chk("wait_start", 32'(bus.start), 32'd0);
      chk("wait_stall", 32'(bus.stall), 32'(stall_exp));
      chk("wait_done", 32'(bus.done), 32'(i == lat));
    end
  endtask

  int s0;

  initial begin
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    bus.md_use   = 1'b0;
    bus.flush    = 1'b0;
    #2;
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_p1", bus.p1, 32'd0);
    chk("rst_p2", bus.p2, 32'd0);
    tick();
    rst_n = 1'b1;

    // Multiply
    tick();
    bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.a = 32'hFFFFFFFE; bus.b = 32'd3;
    smp();
    chk("mul_acc_stall", 32'(bus.stall), 32'd0);
    chk("mul_acc_start", 32'(bus.start), 32'd0);
    tick();
    bus.op_valid = 1'b0;
    smp();
    chk("mul_start", 32'(bus.start), 32'd1);
    chk("mul_p1", bus.p1, 32'hFFFFFFFE);
    chk("mul_p2", bus.p2, 32'd3);
    wait_phase(5, 1'b0);
    tick();
    smp();
    chk("mul_idle_done", 32'(bus.done), 32'd0);
    chk("mul_err", 32'(bus.err), 32'd0);

    // Divide with HI/LO user stalled throughout
    tick();
    bus.op_valid = 1'b1; bus.op_code = 3'd4; bus.a = 32'd100; bus.b = 32'd7;
    smp();
    tick();
    bus.op_valid = 1'b0; bus.md_use = 1'b1;
    smp();
    chk("div_start", 32'(bus.start), 32'd4);
    chk("div_p1", bus.p1, 32'd100);
    chk("div_p2", bus.p2, 32'd7);
    chk("div_issue_stall", 32'(bus.stall), 32'd1);
    wait_phase(10, 1'b1);
    tick();
    smp();
    chk("div_idle_stall", 32'(bus.stall), 32'd0);
    chk("div_idle_start", 32'(bus.start), 32'd0);
    bus.md_use = 1'b0;

    // Back-to-back: div then mult held on op_valid
    tick();
    s0 = nstart;
    bus.op_valid = 1'b1; bus.op_code = 3'd3; bus.a = 32'd50; bus.b = 32'd5;
    smp();
    chk("b2b_acc_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.op_code = 3'd1; bus.a = 32'd6; bus.b = 32'd9;
    smp();
    chk("b2b_div_start", 32'(bus.start), 32'd3);
    chk("b2b_div_p1", bus.p1, 32'd50);
    chk("b2b_issue_stall", 32'(bus.stall), 32'd1);
    wait_phase(10, 1'b1);
    tick();
    smp();
    chk("b2b_acc_stall2", 32'(bus.stall), 32'd0);
    chk("b2b_acc_start2", 32'(bus.start), 32'd0);
    tick();
    bus.op_valid = 1'b0;
    smp();
    chk("b2b_mul_start", 32'(bus.start), 32'd1);
    chk("b2b_mul_p1", bus.p1, 32'd6);
    chk("b2b_mul_p2", bus.p2, 32'd9);
    wait_phase(5, 1'b0);
    tick();
    smp();
    chk("b2b_nstart", 32'(nstart - s0), 32'd2);
    chk("b2b_err", 32'(bus.err), 32'd0);

    // Flush in ISSUE
    tick();
    bus.op_valid = 1'b1; bus.op_code = 3'd2; bus.a = 32'd11; bus.b = 32'd22;
    smp();
    tick();
    bus.op_valid = 1'b0; bus.flush = 1'b1;
    smp();
    chk("fl_start", 32'(bus.start), 32'd0);
    tick();
    bus.flush = 1'b0; bus.md_use = 1'b1;
    smp();
    chk("fl_idle_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.md_use = 1'b0;
    smp();
    chk("fl_err", 32'(bus.err), 32'd0);

    // Flush with op_valid in IDLE is not accepted; neither is an illegal op_code
    tick();
    bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.flush = 1'b1;
    smp();
    tick();
    bus.op_valid = 1'b0; bus.flush = 1'b0; bus.md_use = 1'b1;
    smp();
    chk("flv_start", 32'(bus.start), 32'd0);
    chk("flv_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.md_use = 1'b0; bus.op_valid = 1'b1; bus.op_code = 3'd5;
    smp();
    tick();
    bus.op_valid = 1'b0; bus.md_use = 1'b1;
    smp();
    chk("badop_start", 32'(bus.start), 32'd0);
    chk("badop_stall", 32'(bus.stall), 32'd0);
    bus.md_use = 1'b0;

    // Busy mismatch in third WAIT cycle
    tick();
    bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.a = 32'd1; bus.b = 32'd2;
    smp();
    tick();
    bus.op_valid = 1'b0;
    smp();
    chk("mm_start", 32'(bus.start), 32'd1);
    tick(); smp();
    tick(); smp();
    tick();
    force_lo = 1'b1;
    smp();
    chk("mm_err_pre", 32'(bus.err), 32'd0);
    tick();
    force_lo = 1'b0;
    smp();
    chk("mm_err_set", 32'(bus.err), 32'd1);
    tick();
    smp();
    chk("mm_done", 32'(bus.done), 32'd1);
    tick();
    bus.op_valid = 1'b1; bus.op_code = 3'd2; bus.a = 32'd3; bus.b = 32'd4;
    smp();
    tick();
    bus.op_valid = 1'b0;
    smp();
    chk("mm_clean_start", 32'(bus.start), 32'd2);
    wait_phase(5, 1'b0);
    tick();
    smp();
    chk("mm_err_sticky", 32'(bus.err), 32'd1);

    // Asynchronous reset mid-WAIT
    tick();
    bus.op_valid = 1'b1; bus.op_code = 3'd4; bus.a = 32'd123; bus.b = 32'd45;
    smp();
    tick();
    bus.op_valid = 1'b0; bus.md_use = 1'b1;
    smp();
    tick(); smp();
    tick(); smp();
    chk("rw_stall_pre", 32'(bus.stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rw_start", 32'(bus.start), 32'd0);
    chk("rw_stall", 32'(bus.stall), 32'd0);
    chk("rw_done", 32'(bus.done), 32'd0);
    chk("rw_err", 32'(bus.err), 32'd0);
    chk("rw_p1", bus.p1, 32'd0);
    chk("rw_p2", bus.p2, 32'd0);
    tick();
    rst_n = 1'b1; bus.md_use = 1'b0;
    tick();
    bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.a = 32'd7; bus.b = 32'd8;
    smp();
    tick();
    bus.op_valid = 1'b0;
    smp();
    chk("rw_mul_start", 32'(bus.start), 32'd1);
    chk("rw_mul_p1", bus.p1, 32'd7);
    chk("rw_mul_p2", bus.p2, 32'd8);
    wait_phase(5, 1'b0);
    tick();
    smp();
    chk("rw_mul_err", 32'(bus.err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
